// File: rtl/iodelay_tap_ctrl_if.sv
// Command/completion bus between the bit-alignment logic and the IODELAY tap sequencer.
interface iodelay_tap_ctrl_if #(
    parameter int LANE_W = 2,
    parameter int DEPTH  = 7
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LANE_W-1:0] cmd_lane;
    logic [DEPTH-1:0]  cmd_tap;
    logic              done;
    logic              done_sat;
    logic              done_err;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_lane, cmd_tap,
        input  cmd_ready, done, done_sat, done_err, busy
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_lane, cmd_tap,
        output cmd_ready, done, done_sat, done_err, busy
    );
endinterface

// File: rtl/iodelay_tap_ctrl.sv
// Tap sequencer for a bank of GTP_IODELAY lanes: pulses LOAD_N / MOVE with DIRECTION setup
// and keeps a per-lane shadow of the current tap.
module iodelay_tap_ctrl #(
    parameter int NUM_LANE  = 4,
    parameter int LANE_W    = 2,
    parameter int DEPTH     = 7,
    parameter int INIT_STEP = 0,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    iodelay_tap_ctrl_if.slave   cmd,
    input  logic [LANE_W-1:0]   tap_rd_lane,
    output logic [DEPTH-1:0]    tap_rd,
    output logic [NUM_LANE-1:0] iod_load_n,
    output logic [NUM_LANE-1:0] iod_move,
    output logic [NUM_LANE-1:0] iod_dir
);
    localparam int CNT_W = 8;
    localparam logic [DEPTH-1:0] UB     = {DEPTH{1'b1}};
    localparam logic [DEPTH-1:0] INIT   = DEPTH'(INIT_STEP);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, MV_HI, MV_LO, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [LANE_W-1:0]               lane_q, lane_d;
    logic [DEPTH-1:0]                tgt_q, tgt_d;
    logic                            sat_q, sat_d, err_q, err_d;
    logic [NUM_LANE-1:0][DEPTH-1:0]  shadow_q, shadow_d;
    logic [NUM_LANE-1:0]             load_n_q, load_n_d, move_q, move_d, dir_q, dir_d;
    logic [DEPTH-1:0]                cur_tap, acc_tap;
    logic                            lane_ok;

    // Shadow muxes: active lane, lane being offered, and the read port.
    always_comb begin
        cur_tap = '0;
        acc_tap = '0;
        tap_rd  = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            if (lane_q == LANE_W'(i))          cur_tap = shadow_q[i];
            if (cmd.cmd_lane == LANE_W'(i))    acc_tap = shadow_q[i];
            if (tap_rd_lane == LANE_W'(i))     tap_rd  = shadow_q[i];
        end
        lane_ok = ({1'b0, cmd.cmd_lane} < (LANE_W+1)'(NUM_LANE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lane_q   <= '0;
            tgt_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            shadow_q <= {NUM_LANE{INIT}};
            load_n_q <= '0;
            move_q   <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            tgt_q    <= tgt_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            load_n_q <= load_n_d;
            move_q   <= move_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        tgt_d    = tgt_q;
        sat_d    = sat_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: if (cmd.cmd_valid) begin
                lane_d = cmd.cmd_lane;
                tgt_d  = acc_tap;
                sat_d  = 1'b0;
                err_d  = 1'b0;
                if (!lane_ok) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // INC/DEC become a GOTO; at a boundary the target stays put.
                    case (cmd.cmd_op)
                        2'b00: begin state_d = LOAD; cnt_d = P_LAST; end
                        2'b01: if (acc_tap == UB) sat_d = 1'b1; else tgt_d = acc_tap + DEPTH'(1);
                        2'b10: if (acc_tap == '0) sat_d = 1'b1; else tgt_d = acc_tap - DEPTH'(1);
                        default: tgt_d = cmd.cmd_tap;
                    endcase
                    if (cmd.cmd_op != 2'b00) begin
                        if (tgt_d == acc_tap) state_d = DONE;
                        else begin state_d = SETUP; cnt_d = S_LAST; end
                    end
                end
            end
            LOAD: if (cnt_q == '0) begin
                state_d = DONE;
                for (int i = 0; i < NUM_LANE; i++)
                    if (lane_q == LANE_W'(i)) shadow_d[i] = INIT;
            end else cnt_d = cnt_q - CNT_W'(1);
            SETUP: if (cnt_q == '0) begin
                state_d = MV_HI;
                cnt_d   = P_LAST;
            end else cnt_d = cnt_q - CNT_W'(1);
            MV_HI: if (cnt_q == '0) begin
                // The primitive steps on MOVE's falling edge, which is this transition.
                state_d = MV_LO;
                cnt_d   = S_LAST;
                for (int i = 0; i < NUM_LANE; i++)
                    if (lane_q == LANE_W'(i))
                        shadow_d[i] = (tgt_q > cur_tap) ? cur_tap + DEPTH'(1) : cur_tap - DEPTH'(1);
            end else cnt_d = cnt_q - CNT_W'(1);
            MV_LO: if (cnt_q == '0) begin
                if (cur_tap == tgt_q) state_d = DONE;
                else begin state_d = MV_HI; cnt_d = P_LAST; end
            end else cnt_d = cnt_q - CNT_W'(1);
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin registers follow the next state so they line up with the state register.
    always_comb begin
        for (int i = 0; i < NUM_LANE; i++) begin
            load_n_d[i] = !(state_d == LOAD && lane_d == LANE_W'(i));
            move_d[i]   = (state_d == MV_HI && lane_d == LANE_W'(i));
            dir_d[i]    = (state_q == IDLE && state_d == SETUP && lane_d == LANE_W'(i))
                          ? (tgt_d < acc_tap) : dir_q[i];
        end
        cmd.cmd_ready = (state_q == IDLE);
        cmd.busy      = (state_q != IDLE);
        cmd.done      = (state_q == DONE);
        cmd.done_sat  = (state_q == DONE) && sat_q;
        cmd.done_err  = (state_q == DONE) && err_q;
        iod_load_n    = load_n_q;
        iod_move      = move_q;
        iod_dir       = dir_q;
    end
endmodule

// File: tb/tb_iodelay_tap_ctrl.sv
// Scoreboard bench for iodelay_tap_ctrl with a pin-level IODELAY tap model per lane.
module tb_iodelay_tap_ctrl;
    localparam int NL = 4, LW = 3, DP = 7, INIT = 0, S = 2, P = 2, UB = 127;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [LW-1:0] tap_rd_lane = '0;
    logic [DP-1:0] tap_rd;
    logic [NL-1:0] iod_load_n, iod_move, iod_dir;

    iodelay_tap_ctrl_if #(.LANE_W(LW), .DEPTH(DP)) bus ();

    iodelay_tap_ctrl #(.NUM_LANE(NL), .LANE_W(LW), .DEPTH(DP), .INIT_STEP(INIT),
                       .SETUP_CYC(S), .PULSE_CYC(P)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(bus), .tap_rd_lane(tap_rd_lane), .tap_rd(tap_rd),
        .iod_load_n(iod_load_n), .iod_move(iod_move), .iod_dir(iod_dir));

    always #5 clk = ~clk;

    typedef struct { int acc; int lat; bit sat; bit err; int lane; int tap; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_err = 0, cyc = 0;
    int exp_sh[NL];
    int mtap[NL];
    logic [NL-1:0] pm = '0, pd = '0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // IODELAY model plus completion monitor.
    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (pm[i] && iod_move[i]) chk("dir_hold", int'(iod_dir[i]), int'(pd[i]));
            if (pm[i] && !iod_move[i])
                mtap[i] = pd[i] ? (mtap[i] > 0 ? mtap[i] - 1 : 0) : (mtap[i] < UB ? mtap[i] + 1 : UB);
            if (!iod_load_n[i]) mtap[i] = INIT;
        end
        pm = iod_move;
        pd = iod_dir;
        if (bus.done) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc - e.acc, e.lat);
                chk("done_sat", int'(bus.done_sat), int'(e.sat));
                chk("done_err", int'(bus.done_err), int'(e.err));
                if (!e.err) chk("model_tap", mtap[e.lane], e.tap);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int lane, input int tap);
        int n = 0;
        exp_t e;
        int cur, tgt, k;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) begin chk("ready_timeout", 0, 1); return; end
        cur = (lane < NL) ? exp_sh[lane] : 0;
        tgt = cur;
        e.acc = cyc; e.sat = 0; e.err = 0; e.lane = lane;
        if (lane >= NL) begin e.err = 1; e.lat = 1; end
        else begin
            case (op)
                2'b00: tgt = INIT;
                2'b01: if (cur == UB) e.sat = 1; else tgt = cur + 1;
                2'b10: if (cur == 0) e.sat = 1; else tgt = cur - 1;
                default: tgt = tap;
            endcase
            k = (tgt > cur) ? tgt - cur : cur - tgt;
            e.lat = (op == 2'b00) ? P + 1 : (k == 0 ? 1 : S + k * (P + S) + 1);
            exp_sh[lane] = tgt;
        end
        e.tap = tgt;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_lane  = LW'(lane);
        bus.cmd_tap   = DP'(tap);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = $urandom_range(3, 0);
        bus.cmd_lane  = LW'($urandom_range(7, 0));
        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin chk("done_timeout", sb.size(), 0); sb.delete(); end
    endtask

    task automatic rd_chk(input int lane, input int exp);
        tap_rd_lane = LW'(lane);
        #1;
        chk($sformatf("tap_rd%0d", lane), int'(tap_rd), exp);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_lane = '0; bus.cmd_tap = '0;
        for (int i = 0; i < NL; i++) begin exp_sh[i] = INIT; mtap[i] = INIT; end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_n", int'(iod_load_n), 0);
        chk("rst_move", int'(iod_move), 0);
        chk("rst_dir", int'(iod_dir), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_load_n", int'(iod_load_n), 4'hF);

        issue(2'b00, 1, 0);   rd_chk(1, 0);
        issue(2'b01, 0, 0);   rd_chk(0, 1);  chk("inc_dir0", int'(iod_dir[0]), 0);
        issue(2'b11, 2, 5);   rd_chk(2, 5);
        issue(2'b11, 2, 2);   rd_chk(2, 2);  chk("dec_dir2", int'(iod_dir[2]), 1);
        issue(2'b11, 3, 127); rd_chk(3, 127);
        issue(2'b01, 3, 0);   rd_chk(3, 127);
        issue(2'b11, 1, 0);
        issue(2'b10, 1, 0);   rd_chk(1, 0);
        issue(2'b11, 2, 2);   rd_chk(2, 2);
        issue(2'b11, 4, 9);
        rd_chk(5, 0);

        // Reset in the middle of a move pulse.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_lane = 3'd2; bus.cmd_tap = 7'd100;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int n = 0; n < 50 && iod_move == '0; n++) @(negedge clk);
        chk("move_seen", int'(iod_move != '0), 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_move", int'(iod_move), 0);
        chk("mrst_load_n", int'(iod_load_n), 0);
        chk("mrst_ready", int'(bus.cmd_ready), 1);
        for (int i = 0; i < NL; i++) begin rd_chk(i, INIT); exp_sh[i] = INIT; end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_rel_load_n", int'(iod_load_n), 4'hF);

        for (int r = 0; r < 40; r++) begin
            int ln, op, tp;
            ln = ($urandom_range(9, 0) == 0) ? 4 : $urandom_range(NL - 1, 0);
            op = $urandom_range(3, 0);
            tp = $urandom_range(UB, 0);
            if (op == 3 && exp_sh[ln % NL] > tp + 20) tp = exp_sh[ln % NL] - $urandom_range(20, 0);
            if (op == 3 && tp > exp_sh[ln % NL] + 20) tp = exp_sh[ln % NL] + $urandom_range(20, 0);
            issue(2'(op), ln, tp);
            for (int i = 0; i < NL; i++) begin
                rd_chk(i, exp_sh[i]);
                chk("model_vs_shadow", mtap[i], exp_sh[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
